// File: rtl/menu_scan_if.sv
// menu_scan_if: keypad, game-core and 7-segment signal bundle for menu_scan_ctrl.
// slave  = the menu controller side, master = the surrounding system / bench.
interface menu_scan_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MODE_W     = 4
);
  logic [3:0]              key_data;
  logic                    game_over;
  logic [7*NUM_DIGITS-1:0] game_seg;
  logic                    is_main;
  logic                    game_start;
  logic [MODE_W-1:0]       mode_sel;
  logic [6:0]              seg_txt;
  logic [NUM_DIGITS-1:0]   seg_com;

  modport slave (
    input  key_data, game_over, game_seg,
    output is_main, game_start, mode_sel, seg_txt, seg_com
  );

  modport master (
    output key_data, game_over, game_seg,
    input  is_main, game_start, mode_sel, seg_txt, seg_com
  );
endinterface

// File: rtl/menu_scan_ctrl.sv
// menu_scan_ctrl: multiplexed N-digit 7-segment driver with a MAIN/SELECT/RUN
// menu FSM, tick-qualified key edge detection and game-mode selection.
// Optional build macro MENU_BLINK_EN: blinks the "PrESS" prompt in MAIN.
module menu_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned MODE_W      = 4,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic      clk,
  input  logic      rst,
  menu_scan_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [6:0]        SEG_ONE   = 7'b0000110;

  typedef enum logic [1:0] {
    ST_MAIN,
    ST_SELECT,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [MODE_W-1:0]     r_mode;
  logic [MODE_W-1:0]     w_mode_nx;
  logic                  r_game_start;
  logic                  w_start_nx;
  logic [DIV_W-1:0]      r_div;
  logic                  w_tick;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_pos;
  logic [3:0]            r_key_q;
  logic                  w_press;
  logic [NUM_DIGITS-1:0] r_seg_com;
  logic [NUM_DIGITS-1:0] w_com_nx;
  logic [6:0]            r_seg_txt;
  logic [6:0]            w_txt_nx;
  logic [3:0]            w_mode_num;
  logic                  w_prompt_off;

  // "PrESS" prompt glyphs for positions 0..4
  function automatic logic [6:0] prompt_font(input int unsigned pos);
    logic [6:0] v;
    case (pos)
      0:       v = 7'b1110011;
      1:       v = 7'b1010000;
      2:       v = 7'b1111001;
      3:       v = 7'b1101101;
      4:       v = 7'b1101101;
      default: v = 7'b0000000;
    endcase
    return v;
  endfunction

  // "SEL" glyphs for positions 0..2
  function automatic logic [6:0] select_font(input int unsigned pos);
    logic [6:0] v;
    case (pos)
      0:       v = 7'b1101101;
      1:       v = 7'b1111001;
      2:       v = 7'b0111000;
      default: v = 7'b0000000;
    endcase
    return v;
  endfunction

  // Decimal digits 1..9 in standard 7-segment form
  function automatic logic [6:0] digit_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_div == DIV_LAST);
  assign w_press    = w_tick && (bus.key_data != 4'd0) && (r_key_q == 4'd0);
  assign w_mode_num = 4'(r_mode) + 4'd1;
  assign w_pos      = LAST_IDX - r_idx;

  // Refresh divider: free-running 0..REFRESH_DIV-1
  always_ff @(posedge clk) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Key history sampled once per scan tick for edge detection
  always_ff @(posedge clk) begin
    if (rst)         r_key_q <= '0;
    else if (w_tick) r_key_q <= bus.key_data;
  end

`ifdef MENU_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_off;
  logic               w_enter_main;

  assign w_enter_main = (r_state != ST_MAIN) && (w_state_nx == ST_MAIN);

  // Blink phase: restarts shown on every entry to MAIN, toggles every BLINK_DIV ticks
  always_ff @(posedge clk) begin
    if (rst || w_enter_main) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_prompt_off = r_blink_off;
`else
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV != 0);
  assign w_prompt_off       = 1'b0;
`endif

  // Menu FSM next state, mode update and start pulse
  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_start_nx = 1'b0;
    unique case (r_state)
      ST_MAIN: begin
        if (w_press && (bus.key_data == 4'd1)) w_state_nx = ST_SELECT;
      end
      ST_SELECT: begin
        if (w_press) begin
          case (bus.key_data)
            4'd1: begin
              w_state_nx = ST_RUN;
              w_start_nx = 1'b1;
            end
            4'd2: w_mode_nx = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
            4'd3: w_mode_nx = (r_mode == '0) ? MODE_LAST : r_mode - 1'b1;
            4'd4: w_state_nx = ST_MAIN;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // first RUN cycle (start pulse high) ignores a stale game_over level
        if (bus.game_over && !r_game_start) w_state_nx = ST_MAIN;
      end
      default: w_state_nx = ST_MAIN;
    endcase
  end

  // Menu FSM state, mode and start pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_MAIN;
      r_mode       <= '0;
      r_game_start <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_mode       <= w_mode_nx;
      r_game_start <= w_start_nx;
    end
  end

  // Segment pattern for the digit at the current scan index
  always_comb begin
    w_txt_nx = '0;
    unique case (r_state)
      ST_MAIN: begin
        if (r_idx == LAST_IDX)  w_txt_nx = SEG_ONE;
        else if (!w_prompt_off) w_txt_nx = prompt_font(32'(r_idx));
      end
      ST_SELECT: begin
        if (r_idx == LAST_IDX) w_txt_nx = digit_font(w_mode_num);
        else                   w_txt_nx = select_font(32'(r_idx));
      end
      ST_RUN: begin
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
          if (r_idx == IDX_W'(d)) w_txt_nx = bus.game_seg[7*d +: 7];
        end
      end
      default: w_txt_nx = '0;
    endcase
  end

  // One-cold common enable; digit 0 (leftmost) sits on the MSB
  always_comb begin
    w_com_nx = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      w_com_nx[d] = (IDX_W'(d) != w_pos);
    end
  end

  // Scan register: latch the current digit's drive, then advance the index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_seg_com <= '1;
      r_seg_txt <= '0;
    end else if (w_tick) begin
      r_seg_com <= w_com_nx;
      r_seg_txt <= w_txt_nx;
      r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  assign bus.is_main    = (r_state != ST_RUN);
  assign bus.game_start = r_game_start;
  assign bus.mode_sel   = r_mode;
  assign bus.seg_txt    = r_seg_txt;
  assign bus.seg_com    = r_seg_com;

endmodule

// File: tb/tb_menu_scan_ctrl.sv
// tb_menu_scan_ctrl: directed vectors for menu_scan_ctrl with REFRESH_DIV=4,
// NUM_DIGITS=8, NUM_MODES=4 (BLINK_DIV=2 when MENU_BLINK_EN is defined).
module tb_menu_scan_ctrl;

  localparam int unsigned NUM_DIGITS  = 8;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned NUM_MODES   = 4;
  localparam int unsigned MODE_W      = 4;
  localparam int unsigned BLINK_DIV   = 2;

  logic clk;
  logic rst;

  menu_scan_if #(.NUM_DIGITS(NUM_DIGITS), .MODE_W(MODE_W)) bus ();

  menu_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .NUM_MODES  (NUM_MODES),
    .MODE_W     (MODE_W),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int tb_cyc  = 0;  // clock edges since reset release
  int tb_tk   = 0;  // scan ticks since reset release
  int main_k0 = 1;  // first tick index counted by the blink phase after MAIN entry

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    tb_cyc++;
    tb_tk = tb_cyc / REFRESH_DIV;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      do edge_step(); while ((tb_cyc % REFRESH_DIV) != 0);
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_data = k;
    tick(1);
    bus.key_data = 4'd0;
    tick(1);
  endtask

  task automatic wait_digit(input int d);
    int n;
    n = 0;
    while ((tb_tk < 1 || ((tb_tk - 1) % NUM_DIGITS) != d) && n < NUM_DIGITS + 1) begin
      tick(1);
      n++;
    end
  endtask

  function automatic logic [7:0] exp_com(input int d);
    logic [7:0] v;
    v = 8'h80;
    return ~(v >> d);
  endfunction

  function automatic logic [6:0] exp_main_txt(input int d);
    logic [6:0] v;
    case (d)
      0:       v = 7'h73;
      1:       v = 7'h50;
      2:       v = 7'h79;
      3:       v = 7'h6D;
      4:       v = 7'h6D;
      7:       v = 7'h06;
      default: v = 7'h00;
    endcase
`ifdef MENU_BLINK_EN
    if (d < 5 && (((tb_tk - main_k0) / int'(BLINK_DIV)) % 2) == 1) v = 7'h00;
`endif
    return v;
  endfunction

  task automatic show(input int d, input logic [6:0] exp);
    wait_digit(d);
    check($sformatf("com_d%0d", d), 32'(bus.seg_com), 32'(exp_com(d)));
    check($sformatf("txt_d%0d", d), 32'(bus.seg_txt), 32'(exp));
  endtask

  task automatic show_main(input int d);
    wait_digit(d);
    check($sformatf("main_com_d%0d", d), 32'(bus.seg_com), 32'(exp_com(d)));
    check($sformatf("main_txt_d%0d", d), 32'(bus.seg_txt), 32'(exp_main_txt(d)));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_com"},   32'(bus.seg_com),    32'h0000_00FF);
    check({tag, "_txt"},   32'(bus.seg_txt),    32'h0);
    check({tag, "_mode"},  32'(bus.mode_sel),   32'h0);
    check({tag, "_main"},  32'(bus.is_main),    32'h1);
    check({tag, "_start"}, 32'(bus.game_start), 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_data  = 4'd0;
    bus.game_over = 1'b0;
    for (int d = 0; d < int'(NUM_DIGITS); d++)
      bus.game_seg[7*d +: 7] = (d == 2) ? 7'h3F : 7'(16 + d);

    // reset and first scan round
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    rst = 1'b0;
    tb_cyc = 0; tb_tk = 0; main_k0 = 1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("pre_tick_com", 32'(bus.seg_com), 32'h0000_00FF);
    end
    for (int k = 0; k < 9; k++) begin
      tick(1);
      check($sformatf("scan%0d_com", k), 32'(bus.seg_com), 32'(exp_com(k % 8)));
      check($sformatf("scan%0d_txt", k), 32'(bus.seg_txt), 32'(exp_main_txt(k % 8)));
    end

    // held key 1: one press only, lands in SELECT
    bus.key_data = 4'd1;
    tick(20);
    bus.key_data = 4'd0;
    tick(1);
    check("hold_main", 32'(bus.is_main), 32'h1);
    check("hold_mode", 32'(bus.mode_sel), 32'h0);
    show(0, 7'h6D);
    show(7, 7'h06);

    // mode wrap both ways
    press(4'd3);
    check("dec_wrap", 32'(bus.mode_sel), 32'h3);
    show(7, 7'h66);
    press(4'd2);
    check("inc_wrap", 32'(bus.mode_sel), 32'h0);
    // 2 -> 3 without release: only the first code counts
    bus.key_data = 4'd2; tick(1);
    bus.key_data = 4'd3; tick(1);
    bus.key_data = 4'd0; tick(1);
    check("roll_mode", 32'(bus.mode_sel), 32'h1);
    show(7, 7'h5B);

    // key 4 back to MAIN, mode retained
    bus.key_data = 4'd4;
    tick(1);
    main_k0 = tb_tk + 1;
    bus.key_data = 4'd0;
    tick(1);
    check("back_mode", 32'(bus.mode_sel), 32'h1);
    show_main(0);
    show_main(7);
    press(4'd1);
    show(7, 7'h5B);

    // start: key 1 sampled on the 4th edge
    bus.key_data = 4'd1;
    edge_step(); edge_step(); edge_step();
    check("start_pre", 32'(bus.game_start), 32'h0);
    edge_step();
    check("start_pulse", 32'(bus.game_start), 32'h1);
    check("run_main", 32'(bus.is_main), 32'h0);
    edge_step();
    check("start_post", 32'(bus.game_start), 32'h0);
    bus.key_data = 4'd0;
    tick(1);
    show(2, 7'h3F);
    show(5, 7'h15);
    press(4'd2);
    check("run_keys_mode", 32'(bus.mode_sel), 32'h1);
    check("run_keys_main", 32'(bus.is_main), 32'h0);

    // game over between ticks
    edge_step();
    bus.game_over = 1'b1;
    edge_step();
    check("over_main", 32'(bus.is_main), 32'h1);
    bus.game_over = 1'b0;
    main_k0 = tb_tk + 1;
    check("over_mode", 32'(bus.mode_sel), 32'h1);
    show_main(0);
    show_main(7);

    // reset mid-SELECT with a key held
    press(4'd1);
    press(4'd2);
    check("pre_rst_mode", 32'(bus.mode_sel), 32'h2);
    bus.key_data = 4'd3;
    edge_step();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1;
    check_idle("rst2");
    rst = 1'b0;
    tb_cyc = 0; tb_tk = 0; main_k0 = 1;
    tick(1);
    bus.key_data = 4'd0;
    check("rst2_mode", 32'(bus.mode_sel), 32'h0);
    check("rst2_txt0", 32'(bus.seg_txt), 32'(exp_main_txt(0)));

    // prompt over several ticks (steady, or blinking with MENU_BLINK_EN)
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("prompt_t%0d", tb_tk), 32'(bus.seg_txt),
            32'(exp_main_txt((tb_tk - 1) % 8)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
